// File: rtl/result_drain.sv
// result_drain: drains the per-channel result memories onto a valid/ready byte stream.
// Define RESULT_DRAIN_HEADER_EN to prefix each drain with the low two bytes of the word count.
module result_drain #(
  parameter int DATA_W = 8,
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        wordCount,
  output logic                     memRdEn,
  output logic [ADDR_W-1:0]        memAddr,
  input  logic [CH_NUM*DATA_W-1:0] memDataIn,
  output logic [DATA_W-1:0]        outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     busy,
  output logic                     done
);
  localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
`ifdef RESULT_DRAIN_HEADER_EN
  typedef enum logic [2:0] {IDLE, HDR, FETCH, CAPTURE, SEND, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, FIN} state_t;
`endif
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt, addr;
  logic [CH_W-1:0] ch;
  logic [CH_NUM*DATA_W-1:0] hold;
  logic xfer, last_ch, last_addr;
`ifdef RESULT_DRAIN_HEADER_EN
  logic hdr_idx;
`endif
  assign xfer = outValid && outReady;
  assign last_ch = ch == CH_W'(CH_NUM - 1);
  // cnt is nonzero whenever SEND is reached, so cnt-1 cannot underflow
  assign last_addr = addr == cnt - ADDR_W'(1);
  assign memRdEn = state == FETCH;
  assign memAddr = addr;
  assign busy = state != IDLE;
  assign done = state == FIN;
  always_comb begin
    outValid = 1'b0;
    outData = '0;
    if (state == SEND) begin
      outValid = 1'b1;
      outData = hold[ch*DATA_W +: DATA_W];
    end
`ifdef RESULT_DRAIN_HEADER_EN
    if (state == HDR) begin
      outValid = 1'b1;
      outData = DATA_W'(hdr_idx ? cnt[15:8] : cnt[7:0]);
    end
`endif
  end
  always_comb begin
    nxt = state;
    case (state)
`ifdef RESULT_DRAIN_HEADER_EN
      IDLE:    if (start) nxt = HDR;
      HDR:     if (xfer && hdr_idx) nxt = cnt == '0 ? FIN : FETCH;
`else
      IDLE:    if (start) nxt = wordCount == '0 ? FIN : FETCH;
`endif
      FETCH:   nxt = CAPTURE;
      CAPTURE: nxt = SEND;
      SEND:    if (xfer && last_ch) nxt = last_addr ? FIN : FETCH;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      ch <= '0;
      hold <= '0;
`ifdef RESULT_DRAIN_HEADER_EN
      hdr_idx <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        cnt <= wordCount;
        addr <= '0;
`ifdef RESULT_DRAIN_HEADER_EN
        hdr_idx <= 1'b0;
`endif
      end
`ifdef RESULT_DRAIN_HEADER_EN
      if (state == HDR && xfer) hdr_idx <= 1'b1;
`endif
      if (state == CAPTURE) begin
        hold <= memDataIn;
        ch <= '0;
      end
      if (state == SEND && xfer) begin
        if (!last_ch) ch <= ch + CH_W'(1);
        else if (!last_addr) addr <= addr + ADDR_W'(1);
      end
    end
  end
endmodule
